// File: rtl/spi_slave.sv
`default_nettype none
// spi_slave: oversampled SPI target decoding {read_write, address, data} frames, MSB first.
// Optional SPI_SLAVE_BURST_EN: keep transferring words at address + 1 while SS stays low.
module spi_slave #(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 15
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     clock_polarity,
   input  logic                     clock_phase,
   input  logic                     serial_clock,
   input  logic                     slave_select,
   input  logic                     master_out_slave_in,
   output logic                     master_in_slave_out,
   output logic                     master_in_slave_out_enable,
   output logic [ADDRESS_WIDTH-1:0] write_address,
   output logic [DATA_WIDTH-1:0]    write_data,
   output logic                     write_valid,
   output logic [ADDRESS_WIDTH-1:0] read_address,
   output logic                     read_request,
   input  logic [DATA_WIDTH-1:0]    read_data,
   input  logic                     read_data_valid,
   output logic                     frame_error,
   output logic                     read_underrun,
   output logic                     busy
);
   localparam int FRAME_MAX = (1 + ADDRESS_WIDTH > DATA_WIDTH) ? 1 + ADDRESS_WIDTH : DATA_WIDTH;
   localparam int CW = $clog2(FRAME_MAX + 1);
   localparam logic [CW-1:0] ADDR_LAST = CW'(ADDRESS_WIDTH);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_ADDRESS, S_WAIT_READ, S_DATA, S_DONE} state_t;
   state_t state, state_next, word_end_state;

   logic [2:0]               sclk_pipe, ss_pipe;
   logic [1:0]               mosi_pipe;
   logic [CW-1:0]            bit_count;
   logic [ADDRESS_WIDTH-1:0] addr_shift, address;
   logic [DATA_WIDTH-2:0]    data_shift;
   logic [DATA_WIDTH-1:0]    tx_shift;
   logic                     miso_bit, is_read, word_seen;

   // SS synchronizer resets low so a frame already in progress produces no fall.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sclk_pipe <= '0;
         ss_pipe   <= '0;
         mosi_pipe <= '0;
      end else begin
         sclk_pipe <= {sclk_pipe[1:0], serial_clock};
         ss_pipe   <= {ss_pipe[1:0], slave_select};
         mosi_pipe <= {mosi_pipe[0], master_out_slave_in};
      end
   end

   logic mosi_sync, leading, trailing, sample_edge, shift_edge, ss_fall, ss_rise;
   assign mosi_sync   = mosi_pipe[1];
   assign leading     = (sclk_pipe[1] != clock_polarity) && (sclk_pipe[2] == clock_polarity);
   assign trailing    = (sclk_pipe[1] == clock_polarity) && (sclk_pipe[2] != clock_polarity);
   assign sample_edge = clock_phase ? trailing : leading;
   assign shift_edge  = clock_phase ? leading : trailing;
   assign ss_fall     = ss_pipe[2] && !ss_pipe[1];
   assign ss_rise     = !ss_pipe[2] && ss_pipe[1];

   logic [ADDRESS_WIDTH:0]  addr_word;
   logic [DATA_WIDTH-1:0]   data_word;
   logic                    addr_last, data_last, boundary;
   assign addr_word = {addr_shift, mosi_sync};
   assign data_word = {data_shift, mosi_sync};
   assign addr_last = (state == S_ADDRESS) && sample_edge && (bit_count == ADDR_LAST);
   assign data_last = (state == S_DATA) && sample_edge && (bit_count == DATA_LAST);
   // Only reachable in burst mode: SS rising between words ends the frame cleanly.
   assign boundary  = word_seen && (bit_count == '0);

`ifdef SPI_SLAVE_BURST_EN
   assign word_end_state = is_read ? S_WAIT_READ : S_DATA;
`else
   assign word_end_state = S_DONE;
`endif

   always_ff @(posedge clock) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (ss_rise && (state != S_IDLE)) begin
         state_next = S_IDLE;
      end else begin
         case (state)
            S_IDLE:      if (ss_fall) state_next = S_ADDRESS;
            S_ADDRESS:   if (addr_last) state_next = addr_word[ADDRESS_WIDTH] ? S_WAIT_READ : S_DATA;
            S_WAIT_READ: if (read_data_valid || shift_edge) state_next = S_DATA;
            S_DATA:      if (data_last) state_next = word_end_state;
            default:     state_next = state;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         bit_count     <= '0;
         addr_shift    <= '0;
         address       <= '0;
         data_shift    <= '0;
         tx_shift      <= '0;
         miso_bit      <= 1'b0;
         is_read       <= 1'b0;
         word_seen     <= 1'b0;
         write_address <= '0;
         write_data    <= '0;
         write_valid   <= 1'b0;
         read_address  <= '0;
         read_request  <= 1'b0;
         frame_error   <= 1'b0;
         read_underrun <= 1'b0;
      end else begin
         write_valid   <= 1'b0;
         read_request  <= 1'b0;
         frame_error   <= 1'b0;
         read_underrun <= 1'b0;
         if (ss_rise && (state != S_IDLE)) begin
            frame_error <= (state != S_DONE) && !boundary;
            miso_bit    <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (ss_fall) begin
                     bit_count  <= '0;
                     addr_shift <= '0;
                     data_shift <= '0;
                     tx_shift   <= '0;
                     miso_bit   <= 1'b0;
                     word_seen  <= 1'b0;
                  end
               end
               S_ADDRESS: begin
                  if (addr_last) begin
                     bit_count <= '0;
                     is_read   <= addr_word[ADDRESS_WIDTH];
                     address   <= addr_word[ADDRESS_WIDTH-1:0];
                     if (addr_word[ADDRESS_WIDTH]) begin
                        read_request <= 1'b1;
                        read_address <= addr_word[ADDRESS_WIDTH-1:0];
                     end
                  end else if (sample_edge) begin
                     addr_shift <= addr_word[ADDRESS_WIDTH-1:0];
                     bit_count  <= bit_count + 1'b1;
                  end
               end
               S_WAIT_READ: begin
                  if (read_data_valid) begin
                     // A shift edge in the same cycle must already present the MSB.
                     if (shift_edge) begin
                        miso_bit <= read_data[DATA_WIDTH-1];
                        tx_shift <= {read_data[DATA_WIDTH-2:0], 1'b0};
                     end else begin
                        miso_bit <= 1'b0;
                        tx_shift <= read_data;
                     end
                  end else if (shift_edge) begin
                     tx_shift      <= '0;
                     miso_bit      <= 1'b0;
                     read_underrun <= 1'b1;
                  end
               end
               S_DATA: begin
                  if (shift_edge) begin
                     miso_bit <= tx_shift[DATA_WIDTH-1];
                     tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                  end
                  if (data_last) begin
                     bit_count <= '0;
                     miso_bit  <= 1'b0;
                     word_seen <= 1'b1;
                     if (!is_read) begin
                        write_valid   <= 1'b1;
                        write_address <= address;
                        write_data    <= data_word;
                     end
`ifdef SPI_SLAVE_BURST_EN
                     address <= address + 1'b1;
                     if (is_read) begin
                        read_request <= 1'b1;
                        read_address <= address + 1'b1;
                     end
`endif
                  end else if (sample_edge) begin
                     data_shift <= data_word[DATA_WIDTH-2:0];
                     bit_count  <= bit_count + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign busy                       = (state != S_IDLE);
   assign master_in_slave_out_enable = busy;
   assign master_in_slave_out        = miso_bit && (state == S_DATA);
endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// Bench for spi_slave: a bit-level SPI master drives frames, a transaction-level model predicts
// write strobes, read requests, underruns, frame errors and the word returned on MISO.
module tb_spi_slave;
   localparam int DW = 16;
   localparam int AW = 15;
   localparam int H  = 10;
`ifdef SPI_SLAVE_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic          clk;
   logic          reset_n, clock_polarity, clock_phase, serial_clock, slave_select, mosi;
   logic          miso, miso_en, write_valid, read_request, read_data_valid;
   logic          frame_error, read_underrun, busy;
   logic [AW-1:0] write_address, read_address;
   logic [DW-1:0] write_data, read_data;

   spi_slave #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
      .clock(clk), .reset_n(reset_n), .clock_polarity(clock_polarity), .clock_phase(clock_phase),
      .serial_clock(serial_clock), .slave_select(slave_select), .master_out_slave_in(mosi),
      .master_in_slave_out(miso), .master_in_slave_out_enable(miso_en),
      .write_address(write_address), .write_data(write_data), .write_valid(write_valid),
      .read_address(read_address), .read_request(read_request), .read_data(read_data),
      .read_data_valid(read_data_valid), .frame_error(frame_error),
      .read_underrun(read_underrun), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_compared   = 0;
   int n_mismatched = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Host memory model: the word any address returns when read.
   function automatic logic [DW-1:0] resp(input logic [AW-1:0] a);
      return {a[6:0], a[14:6]} ^ 16'hC3A5;
   endfunction

   // Monitor (sole writer of these records).
   logic [AW+DW-1:0] wv_q[$];
   int fe_cnt = 0;
   int ur_cnt = 0;
   always @(negedge clk) begin
      if (write_valid)   wv_q.push_back({write_address, write_data});
      if (frame_error)   fe_cnt++;
      if (read_underrun) ur_cnt++;
   end

   // Host responder: answers read_request after host_delay clocks, or never.
   logic [AW-1:0] rr_q[$];
   bit            host_answer, host_override, noise_en;
   int            host_delay;
   logic [DW-1:0] host_value;
   initial begin
      logic [AW-1:0] a;
      read_data_valid = 1'b0;
      read_data       = '0;
      forever begin
         @(negedge clk);
         read_data_valid = 1'b0;
         read_data       = 16'($urandom);
         if (read_request) begin
            a = read_address;
            rr_q.push_back(a);
            if (host_answer) begin
               repeat (host_delay - 1) @(negedge clk);
               read_data_valid = 1'b1;
               read_data       = host_override ? host_value : resp(a);
            end
         end else if (noise_en && ($urandom_range(0, 7) == 0)) begin
            read_data_valid = 1'b1;
         end
      end
   end

   logic [1:0] mid_flags;

   task automatic spi_frame(input logic cpol, input logic cpha, input logic [63:0] bits,
                            input int nbits, output logic [63:0] cap);
      cap = '0;
      clock_polarity = cpol;
      clock_phase    = cpha;
      serial_clock   = cpol;
      repeat (H) @(negedge clk);
      slave_select = 1'b0;
      if (!cpha) mosi = bits[63];
      repeat (H) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         if (cpha) begin
            serial_clock = ~cpol;
            mosi = bits[63-i];
            repeat (H) @(negedge clk);
            cap[63-i] = miso;
            serial_clock = cpol;
            repeat (H) @(negedge clk);
         end else begin
            cap[63-i] = miso;
            serial_clock = ~cpol;
            repeat (H) @(negedge clk);
            serial_clock = cpol;
            if (i + 1 < nbits) mosi = bits[62-i];
            repeat (H) @(negedge clk);
         end
         if (i == 8) mid_flags = {busy, miso_en};
      end
      slave_select = 1'b1;
      repeat (2 * H) @(negedge clk);
   endtask

   task automatic do_frame(input logic cpol, input logic cpha, input logic rw,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [DW-1:0] exp_rd, input int exp_ur);
      logic [63:0]   cap;
      logic [AW:0]   got_addr;
      logic [AW+DW:0] got_word;
      int wv0, rr0, fe0, ur0;
      wv0 = wv_q.size(); rr0 = rr_q.size(); fe0 = fe_cnt; ur0 = ur_cnt;
      mid_flags = 2'b00;
      spi_frame(cpol, cpha, {rw, addr, data, 32'h0}, 32, cap);
      check("busy_mid", mid_flags, 2'b11);
      check("idle_end", {busy, miso_en, miso}, 3'b000);
      check("frame_err", fe_cnt - fe0, 0);
      if (rw) begin
         got_addr = (rr_q.size() > rr0) ? {1'b0, rr_q[rr0]} : {1'b1, {AW{1'b0}}};
         check("rd_req_n", rr_q.size() - rr0, BURST ? 2 : 1);
         check("rd_addr", got_addr, {1'b0, addr});
         check("rd_data", cap[47:32], exp_rd);
         check("underrun", ur_cnt - ur0, exp_ur * ((BURST && !cpha) ? 2 : 1));
         check("wr_n", wv_q.size() - wv0, 0);
      end else begin
         got_word = (wv_q.size() > wv0) ? {1'b0, wv_q[wv0]} : {1'b1, {(AW+DW){1'b0}}};
         check("wr_n", wv_q.size() - wv0, 1);
         check("wr_word", got_word, {1'b0, addr, data});
         check("rd_req_n", rr_q.size() - rr0, 0);
         check("underrun", ur_cnt - ur0, 0);
      end
   endtask

   logic [63:0] cap_main;
   int          wv_b, fe_b, rr_b;
   logic        rcpol, rcpha, rrw;
   logic [AW-1:0] raddr;
   logic [DW-1:0] rdat, d0, d1, d2;

   initial begin
      reset_n = 1'b0; clock_polarity = 1'b0; clock_phase = 1'b0; serial_clock = 1'b0;
      slave_select = 1'b1; mosi = 1'b0; mid_flags = 2'b00;
      host_answer = 1'b1; host_override = 1'b0; host_value = '0; host_delay = 2; noise_en = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_ctl", {write_valid, read_request, frame_error, read_underrun, busy, miso, miso_en}, 7'b0);
      check("rst_wr", {write_address, write_data}, 0);
      check("rst_rd_addr", read_address, 0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      do_frame(1'b0, 1'b0, 1'b0, 15'h1234, 16'hBEEF, 16'h0, 0);

      host_override = 1'b1; host_value = 16'hA5C3; host_delay = 2;
      do_frame(1'b1, 1'b1, 1'b1, 15'h0007, 16'h0F0F, 16'hA5C3, 0);
      host_override = 1'b0;

      host_answer = 1'b0;
      do_frame(1'b0, 1'b0, 1'b1, 15'h0010, 16'hFFFF, 16'h0000, 1);
      host_answer = 1'b1;

      // SS released after 8 data bits of a write.
      wv_b = wv_q.size(); fe_b = fe_cnt;
      spi_frame(1'b0, 1'b0, {1'b0, 15'h2222, 16'h1357, 32'h0}, 24, cap_main);
      check("abort_fe", fe_cnt - fe_b, 1);
      check("abort_wr", wv_q.size() - wv_b, 0);
      do_frame(1'b0, 1'b0, 1'b0, 15'h2222, 16'h1357, 16'h0, 0);

      // Reset pulse in the middle of a write frame.
      wv_b = wv_q.size(); fe_b = fe_cnt; rr_b = rr_q.size();
      fork
         spi_frame(1'b0, 1'b1, {1'b0, 15'h0ABC, 16'h4321, 32'h0}, 32, cap_main);
         begin
            repeat (200) @(negedge clk);
            reset_n = 1'b0;
            @(negedge clk);
            check("rst_mid_ctl", {write_valid, read_request, frame_error, read_underrun, busy, miso, miso_en}, 7'b0);
            reset_n = 1'b1;
         end
      join
      check("rst_mid_wr", wv_q.size() - wv_b, 0);
      check("rst_mid_fe", fe_cnt - fe_b, 0);
      check("rst_mid_rr", rr_q.size() - rr_b, 0);
      do_frame(1'b0, 1'b1, 1'b0, 15'h0ABC, 16'h4321, 16'h0, 0);

      noise_en = 1'b1;
      for (int n = 0; n < 24; n++) begin
         rcpol = 1'($urandom); rcpha = 1'($urandom); rrw = 1'($urandom);
         raddr = 15'($urandom); rdat = 16'($urandom);
         host_delay = $urandom_range(1, 4);
         do_frame(rcpol, rcpha, rrw, raddr, rdat, resp(raddr), 0);
      end
      noise_en = 1'b0;

`ifdef SPI_SLAVE_BURST_EN
      d0 = 16'($urandom); d1 = 16'($urandom); d2 = 16'($urandom);
      wv_b = wv_q.size(); fe_b = fe_cnt;
      spi_frame(1'b0, 1'b0, {1'b0, 15'h7FFF, d0, d1, d2}, 64, cap_main);
      check("burst_n", wv_q.size() - wv_b, 3);
      check("burst_fe", fe_cnt - fe_b, 0);
      check("burst_w0", wv_q[wv_b],     {15'h7FFF, d0});
      check("burst_w1", wv_q[wv_b + 1], {15'h0000, d1});
      check("burst_w2", wv_q[wv_b + 2], {15'h0001, d2});
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench did not complete");
   end
endmodule
`default_nettype wire
